// File: rtl/mc_port_pkg.sv
// Shared MC command codes, flush FSM states and request/response field bundles
// for the per-port MC adapter.
package mc_port_pkg;

  localparam logic [2:0] MC_CMD_RD  = 3'd1;
  localparam logic [2:0] MC_CMD_WR  = 3'd2;
  localparam logic [2:0] RS_RD_DATA = 3'd2;
  localparam logic [2:0] RS_WR_CMP  = 3'd3;

  typedef enum logic [1:0] {FL_IDLE, FL_DRAIN, FL_ISSUE, FL_WAIT} flush_state_e;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [1:0]  size;
    logic [47:0] vadr;
    logic [63:0] data;
  } mc_rq_hdr_t;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [63:0] data;
  } mc_rs_hdr_t;

  // Only read data and write completions retire an outstanding request.
  function automatic logic is_rs_retire(input logic [2:0] cmd);
    return (cmd == RS_RD_DATA) || (cmd == RS_WR_CMP);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO only lands
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mc_rq_port_adapter.sv
// Adapter between personality valid/ready traffic and one Convey MC port:
// queued request issue, response capture with stall headroom, write-flush sequencing.
module mc_rq_port_adapter import mc_port_pkg::*; #(
  parameter int RTNCTL_WIDTH    = 32,
  parameter int RQ_DEPTH        = 8,
  parameter int RS_DEPTH        = 4,
  parameter int RS_HEADROOM     = 2,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                              clk,
  input  logic                              i_reset_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [2:0]                        req_cmd,
  input  logic [3:0]                        req_scmd,
  input  logic [1:0]                        req_size,
  input  logic [47:0]                       req_vadr,
  input  logic [63:0]                       req_data,
  input  logic [RTNCTL_WIDTH-1:0]           req_rtnctl,
  output logic                              mc_rq_vld,
  output logic [2:0]                        mc_rq_cmd,
  output logic [3:0]                        mc_rq_scmd,
  output logic [1:0]                        mc_rq_size,
  output logic [47:0]                       mc_rq_vadr,
  output logic [63:0]                       mc_rq_data,
  output logic [RTNCTL_WIDTH-1:0]           mc_rq_rtnctl,
  input  logic                              mc_rq_stall,
  input  logic                              mc_rs_vld,
  input  logic [2:0]                        mc_rs_cmd,
  input  logic [3:0]                        mc_rs_scmd,
  input  logic [63:0]                       mc_rs_data,
  input  logic [RTNCTL_WIDTH-1:0]           mc_rs_rtnctl,
  output logic                              mc_rs_stall,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [2:0]                        rsp_cmd,
  output logic [3:0]                        rsp_scmd,
  output logic [63:0]                       rsp_data,
  output logic [RTNCTL_WIDTH-1:0]           rsp_rtnctl,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic                              mc_rq_flush,
  input  logic                              mc_rs_flush_cmplt,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              idle
);

  localparam int RQ_W = $bits(mc_rq_hdr_t) + RTNCTL_WIDTH;
  localparam int RS_W = $bits(mc_rs_hdr_t) + RTNCTL_WIDTH;
  localparam int OW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int RSCW = $clog2(RS_DEPTH) + 1;

  flush_state_e              state;
  logic                      err_flag;
  logic                      rq_full, rq_empty, rq_push, issue;
  logic [$clog2(RQ_DEPTH):0] rq_count;
  logic [RQ_W-1:0]           rq_rdata;
  mc_rq_hdr_t                rq_hdr;
  logic [RTNCTL_WIDTH-1:0]   rq_tag;
  logic                      rs_full, rs_empty, rs_pop, rs_push_ok, rs_retire;
  logic [RSCW-1:0]           rs_count, rs_next;
  logic [RS_W-1:0]           rs_rdata;
  mc_rs_hdr_t                rs_hdr;
  logic [RTNCTL_WIDTH-1:0]   rs_tag;

  // Ready depends only on registered state, so a full FIFO never sees a push.
  assign req_ready = !rq_full && (state == FL_IDLE);
  assign rq_push   = req_valid && req_ready;
  assign issue     = !rq_empty && !mc_rq_stall && (outstanding < OW'(MAX_OUTSTANDING))
                     && (state != FL_ISSUE);
  assign {rq_hdr, rq_tag} = rq_rdata;

  sync_fifo #(.WIDTH(RQ_W), .DEPTH(RQ_DEPTH)) u_rq_fifo (
    .clk(clk), .rst_n(i_reset_n),
    .push(rq_push),
    .wdata({req_cmd, req_scmd, req_size, req_vadr, req_data, req_rtnctl}),
    .pop(issue), .rdata(rq_rdata),
    .full(rq_full), .empty(rq_empty), .count(rq_count)
  );

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mc_rq_vld    <= 1'b0;
      mc_rq_cmd    <= '0;
      mc_rq_scmd   <= '0;
      mc_rq_size   <= '0;
      mc_rq_vadr   <= '0;
      mc_rq_data   <= '0;
      mc_rq_rtnctl <= '0;
    end else begin
      mc_rq_vld <= issue;
      if (issue) begin
        mc_rq_cmd    <= rq_hdr.cmd;
        mc_rq_scmd   <= rq_hdr.scmd;
        mc_rq_size   <= rq_hdr.size;
        mc_rq_vadr   <= rq_hdr.vadr;
        mc_rq_data   <= rq_hdr.data;
        mc_rq_rtnctl <= rq_tag;
      end
    end
  end

  // Responses are captured even while stalled; the MC may still be delivering.
  assign rsp_valid  = !rs_empty;
  assign rs_pop     = rsp_valid && rsp_ready;
  assign rs_push_ok = mc_rs_vld && (!rs_full || rs_pop);
  assign rs_next    = rs_count + RSCW'(rs_push_ok) - RSCW'(rs_pop);
  assign rs_retire  = mc_rs_vld && is_rs_retire(mc_rs_cmd);
  assign {rs_hdr, rs_tag} = rs_rdata;
  assign rsp_cmd    = rsp_valid ? rs_hdr.cmd  : '0;
  assign rsp_scmd   = rsp_valid ? rs_hdr.scmd : '0;
  assign rsp_data   = rsp_valid ? rs_hdr.data : '0;
  assign rsp_rtnctl = rsp_valid ? rs_tag      : '0;

  sync_fifo #(.WIDTH(RS_W), .DEPTH(RS_DEPTH)) u_rs_fifo (
    .clk(clk), .rst_n(i_reset_n),
    .push(mc_rs_vld),
    .wdata({mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl}),
    .pop(rs_pop), .rdata(rs_rdata),
    .full(rs_full), .empty(rs_empty), .count(rs_count)
  );

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      outstanding <= '0;
      mc_rs_stall <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      mc_rs_stall <= (RSCW'(RS_DEPTH) - rs_next) < RSCW'(RS_HEADROOM);
      if (issue && !rs_retire) outstanding <= outstanding + 1'b1;
      else if (!issue && rs_retire) begin
        if (outstanding == '0) err_flag <= 1'b1;
        else                   outstanding <= outstanding - 1'b1;
      end
      if (mc_rs_vld && rs_full && !rs_pop) err_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= FL_IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        FL_IDLE:  if (flush_req) state <= FL_DRAIN;
        FL_DRAIN: if (rq_empty && (outstanding == '0) && !mc_rq_vld) state <= FL_ISSUE;
        FL_ISSUE: state <= FL_WAIT;
        FL_WAIT:  if (mc_rs_flush_cmplt) begin
                    state      <= FL_IDLE;
                    flush_done <= 1'b1;
                  end
        default:  state <= FL_IDLE;
      endcase
    end
  end

  assign mc_rq_flush = (state == FL_ISSUE);
  assign idle = (rq_count == '0) && rs_empty && (outstanding == '0) && (state == FL_IDLE);

endmodule

// File: tb/tb_mc_rq_port_adapter.sv
// Directed bench for mc_rq_port_adapter: issue timing, stall/backpressure,
// response ordering, flush sequencing and asynchronous reset.
module tb_mc_rq_port_adapter;
  import mc_port_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_cmd = '0;
  logic [3:0]  req_scmd = '0;
  logic [1:0]  req_size = '0;
  logic [47:0] req_vadr = '0;
  logic [63:0] req_data = '0;
  logic [31:0] req_rtnctl = '0;
  logic        mc_rq_vld;
  logic [2:0]  mc_rq_cmd;
  logic [3:0]  mc_rq_scmd;
  logic [1:0]  mc_rq_size;
  logic [47:0] mc_rq_vadr;
  logic [63:0] mc_rq_data;
  logic [31:0] mc_rq_rtnctl;
  logic        mc_rq_stall = 1'b0;
  logic        mc_rs_vld = 1'b0;
  logic [2:0]  mc_rs_cmd = '0;
  logic [3:0]  mc_rs_scmd = '0;
  logic [63:0] mc_rs_data = '0;
  logic [31:0] mc_rs_rtnctl = '0;
  logic        mc_rs_stall, rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_cmd;
  logic [3:0]  rsp_scmd;
  logic [63:0] rsp_data;
  logic [31:0] rsp_rtnctl;
  logic        flush_req = 1'b0, flush_done, mc_rq_flush;
  logic        mc_rs_flush_cmplt = 1'b0;
  logic [6:0]  outstanding;
  logic        idle;

  int checks = 0, errors = 0;
  int k, n;
  logic acc;

  mc_rq_port_adapter dut (
    .clk(clk), .i_reset_n(i_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_scmd(req_scmd),
    .req_size(req_size), .req_vadr(req_vadr), .req_data(req_data), .req_rtnctl(req_rtnctl),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_size(mc_rq_size), .mc_rq_vadr(mc_rq_vadr), .mc_rq_data(mc_rq_data),
    .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cmd(rsp_cmd), .rsp_scmd(rsp_scmd),
    .rsp_data(rsp_data), .rsp_rtnctl(rsp_rtnctl),
    .flush_req(flush_req), .flush_done(flush_done), .mc_rq_flush(mc_rq_flush),
    .mc_rs_flush_cmplt(mc_rs_flush_cmplt), .outstanding(outstanding), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rq(input logic [2:0] cmd, input logic [47:0] vadr, input logic [31:0] tag);
    req_cmd    = cmd;
    req_scmd   = 4'h0;
    req_size   = 2'd3;
    req_vadr   = vadr;
    req_data   = {16'h0, vadr};
    req_rtnctl = tag;
  endtask

  task automatic drive_rs(input logic [2:0] cmd, input logic [63:0] data, input logic [31:0] tag);
    mc_rs_vld    = 1'b1;
    mc_rs_cmd    = cmd;
    mc_rs_scmd   = 4'h0;
    mc_rs_data   = data;
    mc_rs_rtnctl = tag;
  endtask

  initial begin
    // Reset state
    #2 i_reset_n = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mc_rq_vld", mc_rq_vld, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mc_rs_stall", mc_rs_stall, 0);
    chk("rst_flush", {flush_done, mc_rq_flush}, 0);
    chk("rst_idle", idle, 1);
    i_reset_n = 1'b1;
    step();

    // Four back-to-back reads: first issue two cycles after first accept
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_rq(MC_CMD_RD, 48'h1000 + 48'(8 * i), 32'(i));
      step();
      if (i == 0) chk("rd_lat_no_vld_yet", mc_rq_vld, 0);
      else begin
        chk("rd_vld", mc_rq_vld, 1);
        chk("rd_vadr", mc_rq_vadr, 48'h1000 + 48'(8 * (i - 1)));
        chk("rd_tag", mc_rq_rtnctl, 32'(i - 1));
      end
    end
    req_valid = 1'b0;
    step();
    chk("rd3_vld", mc_rq_vld, 1);
    chk("rd3_vadr", mc_rq_vadr, 48'h1018);
    chk("rd3_cmd", mc_rq_cmd, MC_CMD_RD);
    step();
    chk("rd_vld_done", mc_rq_vld, 0);
    chk("rd_vadr_hold", mc_rq_vadr, 48'h1018);
    chk("outstanding_4", outstanding, 4);

    // Four RS_RD_DATA responses with consumer stalled
    for (int i = 0; i < 4; i++) begin
      drive_rs(RS_RD_DATA, 64'hA0 + 64'(i), 32'(i));
      step();
      chk("rs_stall_fill", mc_rs_stall, (i >= 2));
    end
    mc_rs_vld = 1'b0;
    chk("outstanding_0", outstanding, 0);
    chk("err_after_fill", dut.err_flag, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_cmd", rsp_cmd, RS_RD_DATA);
      chk("rsp_data", rsp_data, 64'hA0 + 64'(i));
      chk("rsp_tag", rsp_rtnctl, 32'(i));
      step();
    end
    rsp_ready = 1'b0;
    chk("rsp_drained", rsp_valid, 0);
    chk("rs_stall_clear", mc_rs_stall, 0);
    chk("idle_after_rd", idle, 1);

    // Ten requests under mc_rq_stall
    mc_rq_stall = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (k < 10);
      drive_rq(MC_CMD_RD, 48'h2000 + 48'(8 * k), 32'h10 + 32'(k));
      chk("stall_req_ready", req_ready, (k < 8));
      acc = req_valid && req_ready;
      step();
      if (acc) k++;
      chk("stall_no_vld", mc_rq_vld, 0);
    end
    chk("stall_accepted", k, 8);
    mc_rq_stall = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      req_valid = (k < 10);
      drive_rq(MC_CMD_RD, 48'h2000 + 48'(8 * k), 32'h10 + 32'(k));
      acc = req_valid && req_ready;
      step();
      if (acc) k++;
      if (mc_rq_vld) begin
        chk("stall_issue_vadr", mc_rq_vadr, 48'h2000 + 48'(8 * n));
        n++;
      end
    end
    req_valid = 1'b0;
    chk("stall_issued_10", n, 10);
    chk("outstanding_10", outstanding, 10);
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rs(RS_RD_DATA, 64'(i), 32'h10 + 32'(i));
      step();
    end
    mc_rs_vld = 1'b0;
    step();
    chk("outstanding_back_0", outstanding, 0);
    chk("rsp_empty_10", rsp_valid, 0);

    // Write flush
    req_valid = 1'b1;
    drive_rq(MC_CMD_WR, 48'h3000, 32'h20);
    step();
    drive_rq(MC_CMD_WR, 48'h3008, 32'h21);
    step();
    req_valid = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("drain_req_ready", req_ready, 0);
    chk("wr1_vld", mc_rq_vld, 1);
    chk("wr1_cmd", mc_rq_cmd, MC_CMD_WR);
    chk("wr_outstanding_2", outstanding, 2);
    mc_rs_flush_cmplt = 1'b1;
    step();
    mc_rs_flush_cmplt = 1'b0;
    chk("cmplt_ignored_done", flush_done, 0);
    chk("cmplt_ignored_ready", req_ready, 0);
    chk("no_flush_early_a", mc_rq_flush, 0);
    drive_rs(RS_WR_CMP, 64'h0, 32'h20);
    step();
    chk("wr_outstanding_1", outstanding, 1);
    chk("no_flush_early_b", mc_rq_flush, 0);
    drive_rs(RS_WR_CMP, 64'h0, 32'h21);
    step();
    mc_rs_vld = 1'b0;
    chk("wr_outstanding_0", outstanding, 0);
    chk("no_flush_early_c", mc_rq_flush, 0);
    step();
    chk("flush_pulse", mc_rq_flush, 1);
    step();
    chk("flush_pulse_end", mc_rq_flush, 0);
    chk("wait_req_ready", req_ready, 0);
    step();
    chk("wait_no_done", flush_done, 0);
    mc_rs_flush_cmplt = 1'b1;
    step();
    mc_rs_flush_cmplt = 1'b0;
    chk("flush_done", flush_done, 1);
    chk("post_flush_ready", req_ready, 1);
    step();
    chk("flush_done_end", flush_done, 0);
    chk("idle_after_flush", idle, 1);

    // Unexpected response: counter saturates, sticky error
    drive_rs(RS_RD_DATA, 64'hBAD, 32'h0);
    step();
    mc_rs_vld = 1'b0;
    chk("underflow_sat", outstanding, 0);
    chk("underflow_err", dut.err_flag, 1);
    step();
    rsp_ready = 1'b0;

    // Reset in the middle of a flush with three requests queued
    req_valid = 1'b1;
    drive_rq(MC_CMD_RD, 48'h4000, 32'h30);
    step();
    drive_rq(MC_CMD_RD, 48'h4008, 32'h31);
    step();
    mc_rq_stall = 1'b1;
    drive_rq(MC_CMD_RD, 48'h4010, 32'h32);
    step();
    drive_rq(MC_CMD_RD, 48'h4018, 32'h33);
    step();
    req_valid = 1'b0;
    flush_req = 1'b1;
    step();
    chk("pre_rst_outstanding", outstanding, 1);
    chk("pre_rst_ready", req_ready, 0);
    chk("pre_rst_idle", idle, 0);
    #3 i_reset_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_outstanding", outstanding, 0);
    chk("arst_vadr", mc_rq_vadr, 0);
    chk("arst_idle", idle, 1);
    chk("arst_err", dut.err_flag, 0);
    flush_req = 1'b0;
    mc_rq_stall = 1'b0;
    step();
    i_reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_rst_no_vld", mc_rq_vld, 0);
    end
    chk("post_rst_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
